mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_pkg.sv | 26 ++
 rtl/mem_arbiter_if.sv | 37 +++
 rtl/rr_pick2.sv | 14 +
 rtl/mem_arbiter.sv | 130 +++++++++++++
 tb/tb_mem_arbiter.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/mem_pkg.sv
// Shared encodings and defaults for the two-port RAM arbiter.
package mem_pkg;

   localparam int unsigned ADDR_W_DEF = 9;
   localparam int unsigned DATA_W_DEF = 16;

   typedef enum logic [1:0] {
      CMD_NONE  = 2'b00,
      CMD_READ  = 2'b01,
      CMD_WRITE = 2'b10,
      CMD_RSVD  = 2'b11
   } mem_cmd_e;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'b00,
      ST_ACCESS = 2'b01,
      ST_RESP   = 2'b10,
      ST_DONE   = 2'b11
   } state_e;

   // NONE and the reserved code never count as a request.
   function automatic logic cmd_is_active(input logic [1:0] cmd);
      return (cmd == CMD_READ) || (cmd == CMD_WRITE);
   endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester ports and RAM bus of the arbiter; master = requesters + RAM, slave = arbiter.
interface mem_arbiter_if #(
   parameter int unsigned ADDR_W = 9,
   parameter int unsigned DATA_W = 16
);
   logic              req0;
   logic [1:0]        cmd0;
   logic [ADDR_W-1:0] addr0;
   logic [DATA_W-1:0] wdata0;
   logic              done0;
   logic [DATA_W-1:0] rdata0;

   logic              req1;
   logic [1:0]        cmd1;
   logic [ADDR_W-1:0] addr1;
   logic [DATA_W-1:0] wdata1;
   logic              done1;
   logic [DATA_W-1:0] rdata1;

   logic [ADDR_W-1:0] ram_addr;
   logic [DATA_W-1:0] ram_din;
   logic              ram_write;
   logic [DATA_W-1:0] ram_dout;

   logic              busy;
   logic              owner;

   modport master (
      output req0, cmd0, addr0, wdata0, req1, cmd1, addr1, wdata1, ram_dout,
      input  done0, rdata0, done1, rdata1, ram_addr, ram_din, ram_write, busy, owner
   );

   modport slave (
      input  req0, cmd0, addr0, wdata0, req1, cmd1, addr1, wdata1, ram_dout,
      output done0, rdata0, done1, rdata1, ram_addr, ram_din, ram_write, busy, owner
   );
endinterface

// File: rtl/rr_pick2.sv
// Two-way round-robin picker: on contention the port other than the last grant wins.
module rr_pick2 (
   input  logic i_req0,
   input  logic i_req1,
   input  logic i_last_grant,
   output logic o_grant_idx_c,
   output logic o_grant_valid_c
);
   always_comb begin
      o_grant_valid_c = i_req0 || i_req1;
      if (i_req0 && i_req1) o_grant_idx_c = !i_last_grant;
      else                  o_grant_idx_c = i_req1;
   end
endmodule

// File: rtl/mem_arbiter.sv
// Fixed-latency two-port arbiter in front of a synchronous-read single-port RAM.
module mem_arbiter
   import mem_pkg::*;
#(
   parameter int unsigned ADDR_W = ADDR_W_DEF,
   parameter int unsigned DATA_W = DATA_W_DEF
) (
   input  logic         clk,
   input  logic         reset,
   mem_arbiter_if.slave bus
);

   state_e            r_state,      w_state_nxt;
   logic [1:0]        r_cmd,        w_cmd_nxt;
   logic              r_owner,      w_owner_nxt;
   logic              r_last_grant, w_last_grant_nxt;
   logic              r_busy,       w_busy_nxt;
   logic              r_done0,      w_done0_nxt;
   logic              r_done1,      w_done1_nxt;
   logic [DATA_W-1:0] r_rdata0,     w_rdata0_nxt;
   logic [DATA_W-1:0] r_rdata1,     w_rdata1_nxt;
   logic [ADDR_W-1:0] r_ram_addr,   w_ram_addr_nxt;
   logic [DATA_W-1:0] r_ram_din,    w_ram_din_nxt;
   logic              r_ram_write,  w_ram_write_nxt;

   logic              w_req0;
   logic              w_req1;
   logic              w_grant_idx;
   logic              w_grant_valid;
   logic [1:0]        w_win_cmd;

   assign w_req0 = bus.req0 && cmd_is_active(bus.cmd0);
   assign w_req1 = bus.req1 && cmd_is_active(bus.cmd1);

   rr_pick2 u_pick (
      .i_req0          (w_req0),
      .i_req1          (w_req1),
      .i_last_grant    (r_last_grant),
      .o_grant_idx_c   (w_grant_idx),
      .o_grant_valid_c (w_grant_valid)
   );

   assign w_win_cmd = w_grant_idx ? bus.cmd1 : bus.cmd0;

   // Next-state and next-output logic.
   always_comb begin
      w_state_nxt      = r_state;
      w_cmd_nxt        = r_cmd;
      w_owner_nxt      = r_owner;
      w_last_grant_nxt = r_last_grant;
      w_ram_addr_nxt   = r_ram_addr;
      w_ram_din_nxt    = r_ram_din;
      w_rdata0_nxt     = r_rdata0;
      w_rdata1_nxt     = r_rdata1;
      w_ram_write_nxt  = 1'b0;
      w_done0_nxt      = 1'b0;
      w_done1_nxt      = 1'b0;

      case (r_state)
         ST_IDLE: begin
            if (w_grant_valid) begin
               w_state_nxt      = ST_ACCESS;
               w_owner_nxt      = w_grant_idx;
               w_last_grant_nxt = w_grant_idx;
               w_cmd_nxt        = w_win_cmd;
               w_ram_addr_nxt   = w_grant_idx ? bus.addr1  : bus.addr0;
               w_ram_din_nxt    = w_grant_idx ? bus.wdata1 : bus.wdata0;
               w_ram_write_nxt  = (w_win_cmd == CMD_WRITE);
            end
         end
         ST_ACCESS: w_state_nxt = ST_RESP;
         ST_RESP: begin
            w_state_nxt = ST_DONE;
            if (r_cmd == CMD_READ) begin
               if (r_owner) w_rdata1_nxt = bus.ram_dout;
               else         w_rdata0_nxt = bus.ram_dout;
            end
            w_done0_nxt = !r_owner;
            w_done1_nxt = r_owner;
         end
         ST_DONE: w_state_nxt = ST_IDLE;
         default: w_state_nxt = ST_IDLE;
      endcase

      w_busy_nxt = (w_state_nxt != ST_IDLE);
   end

   // State and output registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state      <= ST_IDLE;
         r_cmd        <= CMD_NONE;
         r_owner      <= 1'b0;
         r_last_grant <= 1'b1;
         r_busy       <= 1'b0;
         r_done0      <= 1'b0;
         r_done1      <= 1'b0;
         r_rdata0     <= '0;
         r_rdata1     <= '0;
         r_ram_addr   <= '0;
         r_ram_din    <= '0;
         r_ram_write  <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_cmd        <= w_cmd_nxt;
         r_owner      <= w_owner_nxt;
         r_last_grant <= w_last_grant_nxt;
         r_busy       <= w_busy_nxt;
         r_done0      <= w_done0_nxt;
         r_done1      <= w_done1_nxt;
         r_rdata0     <= w_rdata0_nxt;
         r_rdata1     <= w_rdata1_nxt;
         r_ram_addr   <= w_ram_addr_nxt;
         r_ram_din    <= w_ram_din_nxt;
         r_ram_write  <= w_ram_write_nxt;
      end
   end

   assign bus.done0    = r_done0;
   assign bus.done1    = r_done1;
   assign bus.rdata0   = r_rdata0;
   assign bus.rdata1   = r_rdata1;
   assign bus.ram_addr = r_ram_addr;
   assign bus.ram_din  = r_ram_din;
   // Gated by reset so an aborted ACCESS cycle can never commit a write.
   assign bus.ram_write = r_ram_write && !reset;
   assign bus.busy     = r_busy;
   assign bus.owner    = r_owner;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural synchronous-read RAM.
module tb_mem_arbiter;

   localparam int unsigned AW = 9;
   localparam int unsigned DW = 16;

   logic clk;
   logic reset;
   logic tb_init;

   int checks = 0;
   int passes = 0;

   mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

   mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [DW-1:0] ram [512];

   always @(posedge clk) begin
      if (tb_init) begin
         ram[9'h005] <= 16'hBEEF;
         ram[9'h00A] <= 16'h0A0A;
         ram[9'h020] <= 16'h7777;
      end else if (bus.ram_write) begin
         ram[bus.ram_addr] <= bus.ram_din;
      end
      bus.ram_dout <= ram[bus.ram_addr];
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) passes++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   task automatic set_p0(input logic req, input logic [1:0] cmd, input logic [AW-1:0] a, input logic [DW-1:0] d);
      bus.req0 = req; bus.cmd0 = cmd; bus.addr0 = a; bus.wdata0 = d;
   endtask

   task automatic set_p1(input logic req, input logic [1:0] cmd, input logic [AW-1:0] a, input logic [DW-1:0] d);
      bus.req1 = req; bus.cmd1 = cmd; bus.addr1 = a; bus.wdata1 = d;
   endtask

   initial begin
      reset = 1'b1;
      tb_init = 1'b1;
      set_p0(1'b0, 2'b00, '0, '0);
      set_p1(1'b0, 2'b00, '0, '0);
      step();
      step();
      // Reset state
      chk("rst_busy",   32'(bus.busy),      32'h0);
      chk("rst_owner",  32'(bus.owner),     32'h0);
      chk("rst_done0",  32'(bus.done0),     32'h0);
      chk("rst_done1",  32'(bus.done1),     32'h0);
      chk("rst_rdata0", 32'(bus.rdata0),    32'h0);
      chk("rst_rdata1", 32'(bus.rdata1),    32'h0);
      chk("rst_raddr",  32'(bus.ram_addr),  32'h0);
      chk("rst_rdin",   32'(bus.ram_din),   32'h0);
      chk("rst_rwr",    32'(bus.ram_write), 32'h0);
      reset = 1'b0;
      tb_init = 1'b0;
      step();

      // Port 0 READ of 5; address changed mid-flight must not matter
      set_p0(1'b1, 2'b01, 9'h005, 16'h0000);
      step();
      chk("rd0_access_addr", 32'(bus.ram_addr),  32'h005);
      chk("rd0_access_busy", 32'(bus.busy),      32'h1);
      chk("rd0_access_wr",   32'(bus.ram_write), 32'h0);
      chk("rd0_access_own",  32'(bus.owner),     32'h0);
      bus.addr0 = 9'h00A;
      step();
      chk("rd0_resp_done0",  32'(bus.done0),     32'h0);
      chk("rd0_resp_addr",   32'(bus.ram_addr),  32'h005);
      step();
      chk("rd0_done0",       32'(bus.done0),     32'h1);
      chk("rd0_rdata0",      32'(bus.rdata0),    32'hBEEF);
      chk("rd0_done1",       32'(bus.done1),     32'h0);
      set_p0(1'b0, 2'b00, '0, '0);
      step();
      chk("rd0_idle_done0",  32'(bus.done0),     32'h0);
      chk("rd0_idle_busy",   32'(bus.busy),      32'h0);

      // Port 1 WRITE 1234 to 1FF
      set_p1(1'b1, 2'b10, 9'h1FF, 16'h1234);
      step();
      chk("wr1_access_wr",   32'(bus.ram_write), 32'h1);
      chk("wr1_access_addr", 32'(bus.ram_addr),  32'h1FF);
      chk("wr1_access_din",  32'(bus.ram_din),   32'h1234);
      chk("wr1_access_own",  32'(bus.owner),     32'h1);
      step();
      chk("wr1_resp_wr",     32'(bus.ram_write), 32'h0);
      step();
      chk("wr1_done1",       32'(bus.done1),     32'h1);
      chk("wr1_done0",       32'(bus.done0),     32'h0);
      chk("wr1_rdata1",      32'(bus.rdata1),    32'h0);
      chk("wr1_done_wr",     32'(bus.ram_write), 32'h0);
      set_p1(1'b0, 2'b00, '0, '0);
      step();

      // Port 0 reads back 1FF
      set_p0(1'b1, 2'b01, 9'h1FF, 16'h0000);
      step();
      step();
      step();
      chk("rb0_done0",       32'(bus.done0),     32'h1);
      chk("rb0_rdata0",      32'(bus.rdata0),    32'h1234);
      set_p0(1'b0, 2'b00, '0, '0);
      step();

      // Both request right after reset: 0 first, then alternate
      reset = 1'b1;
      step();
      reset = 1'b0;
      set_p0(1'b1, 2'b01, 9'h005, 16'h0000);
      set_p1(1'b1, 2'b01, 9'h1FF, 16'h0000);
      step();
      chk("rr_g1_owner",     32'(bus.owner),     32'h0);
      step();
      step();
      chk("rr_t3_done0",     32'(bus.done0),     32'h1);
      chk("rr_t3_done1",     32'(bus.done1),     32'h0);
      chk("rr_t3_rdata0",    32'(bus.rdata0),    32'hBEEF);
      step();
      chk("rr_t4_busy",      32'(bus.busy),      32'h0);
      step();
      chk("rr_g2_owner",     32'(bus.owner),     32'h1);
      step();
      step();
      chk("rr_t7_done1",     32'(bus.done1),     32'h1);
      chk("rr_t7_done0",     32'(bus.done0),     32'h0);
      chk("rr_t7_rdata1",    32'(bus.rdata1),    32'h1234);
      step();
      step();
      chk("rr_g3_owner",     32'(bus.owner),     32'h0);
      step();
      step();
      chk("rr_g3_done0",     32'(bus.done0),     32'h1);
      step();
      step();
      chk("rr_g4_owner",     32'(bus.owner),     32'h1);
      set_p0(1'b0, 2'b00, '0, '0);
      set_p1(1'b0, 2'b00, '0, '0);
      step();
      step();
      chk("rr_g4_done1",     32'(bus.done1),     32'h1);
      step();

      // NONE and reserved commands are ignored
      set_p0(1'b1, 2'b00, 9'h005, 16'hDEAD);
      for (int i = 0; i < 2; i++) begin
         step();
         chk("none_busy",    32'(bus.busy),      32'h0);
         chk("none_wr",      32'(bus.ram_write), 32'h0);
         chk("none_done0",   32'(bus.done0),     32'h0);
      end
      bus.cmd0 = 2'b11;
      for (int i = 0; i < 2; i++) begin
         step();
         chk("rsvd_busy",    32'(bus.busy),      32'h0);
         chk("rsvd_wr",      32'(bus.ram_write), 32'h0);
         chk("rsvd_done0",   32'(bus.done0),     32'h0);
      end
      set_p0(1'b0, 2'b00, '0, '0);
      step();

      // Reset during ACCESS of a port 1 WRITE aborts it
      set_p1(1'b1, 2'b10, 9'h020, 16'h5555);
      step();
      chk("abort_pre_wr",    32'(bus.ram_write), 32'h1);
      reset = 1'b1;
      #1;
      chk("abort_wr",        32'(bus.ram_write), 32'h0);
      step();
      reset = 1'b0;
      set_p1(1'b0, 2'b00, '0, '0);
      chk("abort_busy",      32'(bus.busy),      32'h0);
      chk("abort_done1",     32'(bus.done1),     32'h0);
      chk("abort_owner",     32'(bus.owner),     32'h0);
      chk("abort_raddr",     32'(bus.ram_addr),  32'h0);
      chk("abort_rdata1",    32'(bus.rdata1),    32'h0);
      chk("abort_ram",       32'(ram[9'h020]),   32'h7777);
      step();
      step();
      chk("abort_late_done1", 32'(bus.done1),    32'h0);

      // Read back the location the aborted write targeted
      set_p0(1'b1, 2'b01, 9'h020, 16'h0000);
      step();
      step();
      step();
      chk("abort_rb_done0",  32'(bus.done0),     32'h1);
      chk("abort_rb_rdata0", 32'(bus.rdata0),    32'h7777);
      set_p0(1'b0, 2'b00, '0, '0);
      step();

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
